// File: rtl/commit_queue_if.sv
// Retire-event bus for commit_queue.
// master: retire source and commit consumer (drives in_*, out_ready).
// slave:  the queue itself (drives in_ready and the registered cmt_* slots).
interface commit_queue_if #(
    parameter int NCHAN = 2
);
    // Retire side
    logic                  in_valid;
    logic                  in_ready;
    logic [63:0]           in_pc;
    logic [31:0]           in_inst;
    logic                  in_wen;
    logic [4:0]            in_wdest;
    logic [63:0]           in_wdata;
    logic                  in_skip;
    logic [63:0]           in_a0;

    // Commit side, channel k in slice k
    logic                  out_ready;
    logic [NCHAN-1:0]      cmt_valid;
    logic [NCHAN*64-1:0]   cmt_pc;
    logic [NCHAN*32-1:0]   cmt_inst;
    logic [NCHAN-1:0]      cmt_wen;
    logic [NCHAN*8-1:0]    cmt_wdest;
    logic [NCHAN*64-1:0]   cmt_wdata;
    logic [NCHAN-1:0]      cmt_skip;

    modport master (
        output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0,
        output out_ready,
        input  in_ready,
        input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0,
        input  out_ready,
        output in_ready,
        output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip
    );
endinterface

// File: rtl/commit_queue.sv
// commit_queue: circular queue of retired instructions drained up to NCHAN
// per cycle into registered commit slots, with trap detection (opcode 7'h6b,
// code taken from a0[7:0]) and cycle / instruction counters that freeze once
// the trap has been committed.
//
// Optional build macro COMMIT_QUEUE_BYPASS_EN: an event arriving into an
// empty queue while the consumer is ready goes straight to commit slot 0 on
// the enqueue edge (1-cycle latency) instead of through the storage.
// Without it every event is written first and drained on a later edge.
//
// DEPTH must be a power of two and at least NCHAN; NCHAN is 1..4.
module commit_queue #(
    parameter int NCHAN = 2,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    commit_queue_if.slave bus,
    output logic          trap_valid,
    output logic [7:0]    trap_code,
    output logic [63:0]   trap_pc,
    output logic [63:0]   cycle_cnt,
    output logic [63:0]   instr_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(NCHAN + 1);
    localparam logic [6:0] TRAP_OPCODE = 7'h6b;

    // Entry storage; validity is defined by the pointers, so no reset needed
    logic [63:0] q_pc    [DEPTH];
    logic [31:0] q_inst  [DEPTH];
    logic        q_wen   [DEPTH];
    logic [4:0]  q_wdest [DEPTH];
    logic [63:0] q_wdata [DEPTH];
    logic        q_skip  [DEPTH];
    logic        q_trap  [DEPTH];
    logic [7:0]  q_code  [DEPTH];

    // Queue control
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          trap_enq;

    // Registered commit slots
    logic [NCHAN-1:0]    cmt_valid_r;
    logic [NCHAN*64-1:0] cmt_pc_r;
    logic [NCHAN*32-1:0] cmt_inst_r;
    logic [NCHAN-1:0]    cmt_wen_r;
    logic [NCHAN*8-1:0]  cmt_wdest_r;
    logic [NCHAN*64-1:0] cmt_wdata_r;
    logic [NCHAN-1:0]    cmt_skip_r;

    // Per-cycle decisions
    logic          in_ready_c;
    logic          in_trap;
    logic          enq_fire;
    logic          byp;
    logic          enq;
    logic [NW-1:0] drain_n;
    logic          drain_trap;
    logic [AW-1:0] trap_idx;
    logic [AW-1:0] rd_idx [NCHAN];
    logic [NW-1:0] n_eff;
    logic          trap_fire;
    logic [7:0]    trap_code_nx;
    logic [63:0]   trap_pc_nx;

    // Only a0[7:0] is ever kept as the trap code
    logic unused_a0;
    assign unused_a0 = ^bus.in_a0[63:8];

    // Modular pointer advance; a constant power-of-two modulus reduces to a mask
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input int inc);
        ptr_add = AW'((int'(p) + inc) % DEPTH);
    endfunction

    // Once a trap has been accepted nothing younger may enter the queue
    assign in_ready_c = (count < CW'(DEPTH)) && !trap_enq;
    assign in_trap    = (bus.in_inst[6:0] == TRAP_OPCODE);
    assign enq_fire   = bus.in_valid && in_ready_c;

`ifdef COMMIT_QUEUE_BYPASS_EN
    assign byp = enq_fire && bus.out_ready && (count == '0);
`else
    assign byp = 1'b0;
`endif

    assign enq = enq_fire && !byp;

    // Pick the oldest min(count, NCHAN) entries, cutting the group after a trap
    always_comb begin
        drain_n    = '0;
        drain_trap = 1'b0;
        trap_idx   = rd_ptr;
        for (int k = 0; k < NCHAN; k++) begin
            rd_idx[k] = ptr_add(rd_ptr, k);
        end
        for (int k = 0; k < NCHAN; k++) begin
            if (!drain_trap && (k < int'(count))) begin
                drain_n = drain_n + NW'(1);
                if (q_trap[rd_idx[k]]) begin
                    drain_trap = 1'b1;
                    trap_idx   = rd_idx[k];
                end
            end
        end
        if (!bus.out_ready) begin
            drain_n    = '0;
            drain_trap = 1'b0;
        end
    end

    // Merge the bypass path with the queue path for slots, trap and counters
    always_comb begin
        n_eff        = drain_n;
        trap_fire    = drain_trap;
        trap_code_nx = q_code[trap_idx];
        trap_pc_nx   = q_pc[trap_idx];
        if (byp) begin
            n_eff        = NW'(1);
            trap_fire    = in_trap;
            trap_code_nx = bus.in_a0[7:0];
            trap_pc_nx   = bus.in_pc;
        end
    end

    // Write accepted events into storage at the write pointer
    always_ff @(posedge clock) begin
        if (enq) begin
            q_pc[wr_ptr]    <= bus.in_pc;
            q_inst[wr_ptr]  <= bus.in_inst;
            q_wen[wr_ptr]   <= bus.in_wen;
            q_wdest[wr_ptr] <= bus.in_wdest;
            q_wdata[wr_ptr] <= bus.in_wdata;
            q_skip[wr_ptr]  <= bus.in_skip;
            q_trap[wr_ptr]  <= in_trap;
            q_code[wr_ptr]  <= bus.in_a0[7:0];
        end
    end

    // Pointer, occupancy and trap-accepted bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            trap_enq <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= ptr_add(wr_ptr, 1);
            end
            rd_ptr <= ptr_add(rd_ptr, int'(drain_n));
            count  <= count + CW'(enq) - CW'(drain_n);
            if (enq_fire && in_trap) begin
                trap_enq <= 1'b1;
            end
        end
    end

    // Load commit slots in age order when the consumer is ready, else hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmt_valid_r <= '0;
            cmt_pc_r    <= '0;
            cmt_inst_r  <= '0;
            cmt_wen_r   <= '0;
            cmt_wdest_r <= '0;
            cmt_wdata_r <= '0;
            cmt_skip_r  <= '0;
        end else if (bus.out_ready) begin
            for (int k = 0; k < NCHAN; k++) begin
                cmt_valid_r[k] <= (k < int'(n_eff));
                if (byp && (k == 0)) begin
                    cmt_pc_r[k*64 +: 64]   <= bus.in_pc;
                    cmt_inst_r[k*32 +: 32] <= bus.in_inst;
                    cmt_wen_r[k]           <= bus.in_wen;
                    cmt_wdest_r[k*8 +: 8]  <= {3'b000, bus.in_wdest};
                    cmt_wdata_r[k*64 +: 64] <= bus.in_wdata;
                    cmt_skip_r[k]          <= bus.in_skip;
                end else if (k < int'(drain_n)) begin
                    cmt_pc_r[k*64 +: 64]   <= q_pc[rd_idx[k]];
                    cmt_inst_r[k*32 +: 32] <= q_inst[rd_idx[k]];
                    cmt_wen_r[k]           <= q_wen[rd_idx[k]];
                    cmt_wdest_r[k*8 +: 8]  <= {3'b000, q_wdest[rd_idx[k]]};
                    cmt_wdata_r[k*64 +: 64] <= q_wdata[rd_idx[k]];
                    cmt_skip_r[k]          <= q_skip[rd_idx[k]];
                end
            end
        end
    end

    // Sticky trap report captured on the edge the trap entry commits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trap_valid <= 1'b0;
            trap_code  <= '0;
            trap_pc    <= '0;
        end else if (!trap_valid && trap_fire) begin
            trap_valid <= 1'b1;
            trap_code  <= trap_code_nx;
            trap_pc    <= trap_pc_nx;
        end
    end

    // Cycle and retired-instruction counters, frozen after the trap commits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (!trap_valid) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_cnt <= instr_cnt + 64'(n_eff);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.cmt_valid = cmt_valid_r;
    assign bus.cmt_pc    = cmt_pc_r;
    assign bus.cmt_inst  = cmt_inst_r;
    assign bus.cmt_wen   = cmt_wen_r;
    assign bus.cmt_wdest = cmt_wdest_r;
    assign bus.cmt_wdata = cmt_wdata_r;
    assign bus.cmt_skip  = cmt_skip_r;
endmodule

// File: tb/tb_commit_queue.sv
// Testbench for commit_queue: a table of fill/drain vectors, hand-written
// latency / trap / mid-run reset sequences, and a randomized run checked
// against a queue-based reference model. Honours COMMIT_QUEUE_BYPASS_EN.
module tb_commit_queue;
    localparam int NCHAN = 2;
    localparam int DEPTH = 8;
`ifdef COMMIT_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;

    commit_queue_if #(.NCHAN(NCHAN)) bus();

    commit_queue #(.NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .trap_valid (trap_valid),
        .trap_code  (trap_code),
        .trap_pc    (trap_pc),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic        skip;
        logic [63:0] a0;
    } ev_t;

    typedef struct {
        bit               v;
        logic [63:0]      pc;
        bit               ordy;
        bit               exp_rdy;
        logic [NCHAN-1:0] exp_cv;
        logic [63:0]      exp_pc0;
        logic [63:0]      exp_icnt;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    ev_t         mq[$];
    bit          m_tenq;
    bit          m_tv;
    logic [7:0]  m_code;
    logic [63:0] m_tpc;
    logic [63:0] m_cyc;
    logic [63:0] m_icnt;
    bit          m_cv[NCHAN];
    ev_t         m_slot[NCHAN];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] a0);
        ev_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.wen   = 1'($urandom_range(0, 1));
        e.wdest = 5'($urandom_range(0, 31));
        e.wdata = {$urandom, $urandom};
        e.skip  = 1'($urandom_range(0, 1));
        e.a0    = a0;
        return e;
    endfunction

    function automatic bit is_trap(input ev_t e);
        return e.inst[6:0] == 7'h6b;
    endfunction

    function automatic bit model_ready();
        return (mq.size() < DEPTH) && !m_tenq;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tenq = 0; m_tv = 0; m_code = '0; m_tpc = '0; m_cyc = '0; m_icnt = '0;
        foreach (m_cv[k]) m_cv[k] = 0;
    endtask

    task automatic note_trap(input ev_t e);
        if (!m_tv) begin
            m_tv = 1; m_code = e.a0[7:0]; m_tpc = e.pc;
        end
    endtask

    task automatic model_edge(input bit v, input ev_t e, input bit ordy);
        bit acc, byp, was_tv, tr;
        int n;
        acc = v && model_ready();
        byp = 0; was_tv = m_tv; tr = 0; n = 0;
`ifdef COMMIT_QUEUE_BYPASS_EN
        byp = acc && ordy && (mq.size() == 0);
`endif
        if (ordy) begin
            foreach (m_cv[k]) m_cv[k] = 0;
            if (byp) begin
                m_slot[0] = e; m_cv[0] = 1; n = 1;
                if (is_trap(e)) note_trap(e);
            end else begin
                while (n < NCHAN && mq.size() > 0 && !tr) begin
                    ev_t x;
                    x = mq.pop_front();
                    m_slot[n] = x; m_cv[n] = 1; n++;
                    if (is_trap(x)) begin tr = 1; note_trap(x); end
                end
            end
        end
        if (acc && !byp) mq.push_back(e);
        if (acc && is_trap(e)) m_tenq = 1;
        if (!was_tv) begin
            m_cyc  = m_cyc + 64'd1;
            m_icnt = m_icnt + 64'(n);
        end
    endtask

    task automatic check_all();
        logic [NCHAN-1:0] ecv;
        for (int k = 0; k < NCHAN; k++) ecv[k] = m_cv[k];
        chk("cmt_valid", 64'(bus.cmt_valid), 64'(ecv));
        for (int k = 0; k < NCHAN; k++) begin
            if (m_cv[k]) begin
                chk($sformatf("cmt_pc[%0d]", k),    bus.cmt_pc[k*64 +: 64], m_slot[k].pc);
                chk($sformatf("cmt_inst[%0d]", k),  64'(bus.cmt_inst[k*32 +: 32]), 64'(m_slot[k].inst));
                chk($sformatf("cmt_wen[%0d]", k),   64'(bus.cmt_wen[k]), 64'(m_slot[k].wen));
                chk($sformatf("cmt_wdest[%0d]", k), 64'(bus.cmt_wdest[k*8 +: 8]), 64'({3'b000, m_slot[k].wdest}));
                chk($sformatf("cmt_wdata[%0d]", k), bus.cmt_wdata[k*64 +: 64], m_slot[k].wdata);
                chk($sformatf("cmt_skip[%0d]", k),  64'(bus.cmt_skip[k]), 64'(m_slot[k].skip));
            end
        end
        chk("trap_valid", 64'(trap_valid), 64'(m_tv));
        if (m_tv) begin
            chk("trap_code", 64'(trap_code), 64'(m_code));
            chk("trap_pc", trap_pc, m_tpc);
        end
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instr_cnt", instr_cnt, m_icnt);
    endtask

    task automatic drive(input bit v, input ev_t e, input bit ordy);
        bus.in_valid  = v;
        bus.in_pc     = e.pc;
        bus.in_inst   = e.inst;
        bus.in_wen    = e.wen;
        bus.in_wdest  = e.wdest;
        bus.in_wdata  = e.wdata;
        bus.in_skip   = e.skip;
        bus.in_a0     = e.a0;
        bus.out_ready = ordy;
    endtask

    // One model-checked cycle
    task automatic step(input bit v, input ev_t e, input bit ordy);
        drive(v, e, ordy);
        #1 chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
        @(posedge clock); #1;
        model_edge(v, e, ordy);
        check_all();
    endtask

    // Unchecked edge for the hand-written sequences
    task automatic edge_drv(input bit v, input ev_t e, input bit ordy);
        drive(v, e, ordy);
        @(posedge clock); #1;
    endtask

    task automatic apply_reset();
        ev_t z;
        z = mk_ev(64'h0, 32'h13, 64'h0);
        drive(0, z, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_cmt_valid", 64'(bus.cmt_valid), 64'h0);
        chk("rst_cmt_pc0", bus.cmt_pc[63:0], 64'h0);
        chk("rst_trap_valid", 64'(trap_valid), 64'h0);
        chk("rst_cycle_cnt", cycle_cnt, 64'h0);
        chk("rst_instr_cnt", instr_cnt, 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t tbl[14];
    ev_t  ev;
    ev_t  base;
    logic [63:0] pc_seq;
    logic [63:0] saved_cyc;
    logic [31:0] r;

    initial begin
        base = mk_ev(64'h0, 32'h13, 64'h0);
        drive(0, base, 0);

        // Fill 8 with consumer stalled, drop a 9th, then drain 2 per edge
        for (int i = 0; i < 8; i++) tbl[i] = '{1, 64'h1000 + 64'(4*i), 0, 1, 2'b00, 64'h0, 64'd0};
        tbl[8] = '{1, 64'h2000, 0, 0, 2'b00, 64'h0, 64'd0};
        tbl[9]  = '{0, 64'h0, 1, 0, 2'b11, 64'h1000, 64'd2};
        tbl[10] = '{0, 64'h0, 1, 1, 2'b11, 64'h1008, 64'd4};
        tbl[11] = '{0, 64'h0, 1, 1, 2'b11, 64'h1010, 64'd6};
        tbl[12] = '{0, 64'h0, 1, 1, 2'b11, 64'h1018, 64'd8};
        tbl[13] = '{0, 64'h0, 1, 1, 2'b00, 64'h0, 64'd8};

        apply_reset();
        for (int i = 0; i < 14; i++) begin
            ev = base;
            ev.pc = tbl[i].pc;
            drive(tbl[i].v, ev, tbl[i].ordy);
            #1 chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
            @(posedge clock); #1;
            chk($sformatf("tbl%0d_cmt_valid", i), 64'(bus.cmt_valid), 64'(tbl[i].exp_cv));
            if (tbl[i].exp_cv[0]) chk($sformatf("tbl%0d_pc0", i), bus.cmt_pc[63:0], tbl[i].exp_pc0);
            if (tbl[i].exp_cv[1]) chk($sformatf("tbl%0d_pc1", i), bus.cmt_pc[127:64], tbl[i].exp_pc0 + 64'd4);
            chk($sformatf("tbl%0d_instr_cnt", i), instr_cnt, tbl[i].exp_icnt);
        end

        // Single event latency
        apply_reset();
        ev = mk_ev(64'h80000000, 32'h00000013, 64'h0);
        edge_drv(1, ev, 1);
        chk("lat_edge1_valid", 64'(bus.cmt_valid), (LAT == 1) ? 64'h1 : 64'h0);
        for (int i = 1; i < LAT; i++) edge_drv(0, ev, 1);
        chk("lat_cmt_valid", 64'(bus.cmt_valid), 64'h1);
        chk("lat_cmt_pc0", bus.cmt_pc[63:0], 64'h80000000);
        chk("lat_instr_cnt", instr_cnt, 64'd1);

        // Trap in the middle of a queued group
        apply_reset();
        edge_drv(1, mk_ev(64'h100, 32'h13, 64'h0), 0);
        edge_drv(1, mk_ev(64'h104, 32'h0000006b, 64'h2A), 0);
        ev = mk_ev(64'h108, 32'h13, 64'h0);
        drive(1, ev, 0);
        #1 chk("trap_in_ready_low", 64'(bus.in_ready), 64'h0);
        @(posedge clock); #1;
        edge_drv(0, ev, 1);
        chk("trap_cmt_valid", 64'(bus.cmt_valid), 64'h3);
        chk("trap_pc0", bus.cmt_pc[63:0], 64'h100);
        chk("trap_pc1", bus.cmt_pc[127:64], 64'h104);
        chk("trap_valid_set", 64'(trap_valid), 64'h1);
        chk("trap_code", 64'(trap_code), 64'h2A);
        chk("trap_pc", trap_pc, 64'h104);
        chk("trap_cycle_cnt", cycle_cnt, 64'd4);
        saved_cyc = cycle_cnt;
        repeat (3) edge_drv(0, ev, 1);
        chk("trap_after_valid", 64'(bus.cmt_valid), 64'h0);
        chk("trap_cycle_frozen", cycle_cnt, saved_cyc);
        chk("trap_instr_frozen", instr_cnt, 64'd2);
        chk("trap_sticky", 64'(trap_valid), 64'h1);

        // Reset pulled with 5 entries still queued
        apply_reset();
        for (int i = 0; i < 7; i++) edge_drv(1, mk_ev(64'h200 + 64'(4*i), 32'h13, 64'h0), 0);
        edge_drv(0, base, 1);
        chk("mid_cmt_valid_pre", 64'(bus.cmt_valid), 64'h3);
        edge_drv(0, base, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_cmt_valid_async", 64'(bus.cmt_valid), 64'h0);
        chk("mid_instr_cnt_async", instr_cnt, 64'h0);
        chk("mid_in_ready_async", 64'(bus.in_ready), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        edge_drv(1, mk_ev(64'h300, 32'h13, 64'h0), 1);
        for (int i = 1; i < LAT; i++) edge_drv(0, base, 1);
        chk("mid_new_valid", 64'(bus.cmt_valid), 64'h1);
        chk("mid_new_pc0", bus.cmt_pc[63:0], 64'h300);
        chk("mid_new_instr_cnt", instr_cnt, 64'd1);
        edge_drv(0, base, 1);
        chk("mid_no_stale", 64'(bus.cmt_valid), 64'h0);

        // Continuous 1/cycle with the consumer always ready
        apply_reset();
        for (int i = 0; i < 20; i++) step(1, mk_ev(64'h400 + 64'(4*i), 32'h13, 64'h0), 1);
        chk("stream_instr_cnt", instr_cnt, 64'(20 - (LAT - 1)));

        // Randomized run against the reference model
        apply_reset();
        pc_seq = 64'h8000_0000;
        for (int blk = 0; blk < 40; blk++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                bit v, o;
                v = ($urandom_range(0, 3) != 0);
                o = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
                r = $urandom;
                if ($urandom_range(0, 59) == 0) ev = mk_ev(pc_seq, {r[31:7], 7'h6b}, {$urandom, $urandom});
                else ev = mk_ev(pc_seq, {r[31:7], 7'h13}, {$urandom, $urandom});
                step(v, ev, o);
                pc_seq = pc_seq + 64'd4;
            end
            if (m_tv) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
